// File: rtl/frame_draw_seq.sv
// Frame redraw sequencer: clears the screen to the background colour,
// then runs the centre-net generator and forwards each net y coordinate
// as one pixel at column NET_X. Finishes with a one-cycle done strobe.
// A sticky err flag is set if the net generator never reports done
// within NET_TIMEOUT cycles of the NET state.
module frame_draw_seq #(
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          NET_X       = 80,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter logic [2:0]  NET_COLOUR  = 3'b111,
    parameter int          NET_TIMEOUT = 300
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [6:0] net_y,
    input  logic       net_done,
    output logic       net_go,
    output logic       net_clr,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] X_LAST   = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST   = 7'(SCREEN_H - 1);
    localparam logic [7:0] NET_COL  = 8'(NET_X);
    localparam logic [8:0] CNT_LAST = 9'(NET_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_NET_RST = 2'd2,
        S_NET     = 2'd3
    } state_t;

    state_t     state_reg,   state_next;
    logic [7:0] x_reg,       x_next;
    logic [6:0] y_reg,       y_next;
    logic [2:0] colour_reg,  colour_next;
    logic       plot_reg,    plot_next;
    logic       net_go_reg,  net_go_next;
    logic       net_clr_reg, net_clr_next;
    logic       busy_reg,    busy_next;
    logic       done_reg,    done_next;
    logic       err_reg,     err_next;
    logic [8:0] cnt_reg,     cnt_next;

    // State and registered outputs; reset wins in every state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            colour_reg  <= '0;
            plot_reg    <= 1'b0;
            net_go_reg  <= 1'b0;
            net_clr_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            colour_reg  <= colour_next;
            plot_reg    <= plot_next;
            net_go_reg  <= net_go_next;
            net_clr_reg <= net_clr_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Next-state and next-output decode; everything holds unless changed,
    // except done which is a single-cycle strobe.
    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        colour_next  = colour_reg;
        plot_next    = plot_reg;
        net_go_next  = net_go_reg;
        net_clr_next = net_clr_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        err_next     = err_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next  = S_CLEAR;
                    x_next      = '0;
                    y_next      = '0;
                    colour_next = BG_COLOUR;
                    plot_next   = 1'b1;
                    busy_next   = 1'b1;
                    err_next    = 1'b0;
                end
            end

            S_CLEAR: begin
                if (x_reg == X_LAST && y_reg == Y_LAST) begin
                    // Last background pixel already out: hand over to the net.
                    plot_next    = 1'b0;
                    net_clr_next = 1'b1;
                    state_next   = S_NET_RST;
                end else if (x_reg == X_LAST) begin
                    x_next    = '0;
                    y_next    = y_reg + 7'd1;
                    plot_next = 1'b1;
                end else begin
                    x_next    = x_reg + 8'd1;
                    plot_next = 1'b1;
                end
            end

            S_NET_RST: begin
                net_clr_next = 1'b0;
                net_go_next  = 1'b1;
                cnt_next     = '0;
                state_next   = S_NET;
            end

            S_NET: begin
                if (net_done || cnt_reg == CNT_LAST) begin
                    // Normal completion or watchdog abort share one exit path.
                    plot_next   = 1'b0;
                    net_go_next = 1'b0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    state_next  = S_IDLE;
                    if (!net_done) begin
                        err_next = 1'b1;
                    end
                end else begin
                    x_next      = NET_COL;
                    y_next      = net_y;
                    colour_next = NET_COLOUR;
                    plot_next   = 1'b1;
                    cnt_next    = cnt_reg + 9'd1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign x       = x_reg;
    assign y       = y_reg;
    assign colour  = colour_reg;
    assign plot    = plot_reg;
    assign net_go  = net_go_reg;
    assign net_clr = net_clr_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;

endmodule
